game_ctrl: RTL

- Master sequencer for the minesweeper datapath (dp).
- Drives the one-hot command strobes start/load/decode/alu/display and forwards the user's cell index.
- Waits on dp's place_done/alu_done/display_done handshakes and tracks the game result and move count.
- Runs on clka, so dp samples stable commands on its negedge phases; includes a watchdog against a hung datapath.

---
 rtl/game_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: master sequencer for the minesweeper datapath (dp).
// Issues one-hot commands (start/load/decode/alu/display), forwards the
// user's cell index, waits on dp done handshakes, and tracks the game
// result and move count. A watchdog faults out of any hung wait state.
//
// Ports:
//   clka, restart                 clock, async active-high reset
//   new_game, guess_valid/data    user requests
//   place_done, alu_done,
//   display_done, gameover, win   dp handshakes and result flags
//   guess_ready                   guess accepted this cycle (WAIT_IN)
//   start/load/decode/alu/display one-hot dp command strobes
//   data                          latched guess index to dp
//   bad_input                     one-cycle pulse on rejected guess
//   game_active, won, move_count  game status
//   fault, state                  watchdog fault flag, debug state code
//
// state   | meaning
// IDLE    | waiting for new_game (fault=1 here means watchdog tripped)
// PLACE   | dp placing mines, wait for place_done
// WAIT_IN | waiting for a user guess
// LOAD    | one-cycle load command
// DECODE  | one-cycle decode command
// ALU     | dp evaluating the guess, wait for alu_done
// DISPLAY | dp updating display, wait for display_done
// OVER    | game finished, result held in won
module game_ctrl #(
    parameter int NCELLS  = 25,
    parameter int TIMEOUT = 200,
    parameter int TW      = 8
) (
    input  logic       clka,
    input  logic       restart,
    input  logic       new_game,
    input  logic       guess_valid,
    input  logic [4:0] guess_data,
    input  logic       place_done,
    input  logic       alu_done,
    input  logic       display_done,
    input  logic       gameover,
    input  logic       win,
    output logic       guess_ready,
    output logic       start,
    output logic       load,
    output logic       decode,
    output logic       alu,
    output logic       display,
    output logic [4:0] data,
    output logic       bad_input,
    output logic       game_active,
    output logic       won,
    output logic [4:0] move_count,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLACE   = 3'd1,
        S_WAIT_IN = 3'd2,
        S_LOAD    = 3'd3,
        S_DECODE  = 3'd4,
        S_ALU     = 3'd5,
        S_DISPLAY = 3'd6,
        S_OVER    = 3'd7
    } state_t;

    localparam logic [4:0]    NCELLS_L = 5'(NCELLS);
    localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);

    state_t        state_r;
    state_t        nxt;
    logic [TW-1:0] wd_cnt;
    logic          wd_expire;
    logic          wd_fire;
    logic          guess_ok;

    assign state     = state_r;
    assign guess_ok  = (guess_data < NCELLS_L);
    // wd_cnt holds (cycles spent in state - 1), so this marks the last allowed cycle
    assign wd_expire = (wd_cnt == WD_LAST);

    always_comb begin
        nxt     = state_r;
        wd_fire = 1'b0;
        case (state_r)
            S_IDLE:    if (new_game) nxt = S_PLACE;
            S_PLACE: begin
                if (place_done)     nxt = S_WAIT_IN;
                else if (wd_expire) begin nxt = S_IDLE; wd_fire = 1'b1; end
            end
            S_WAIT_IN: begin
                if (new_game)                     nxt = S_PLACE;
                else if (guess_valid && guess_ok) nxt = S_LOAD;
            end
            S_LOAD:    nxt = S_DECODE;
            S_DECODE:  nxt = S_ALU;
            S_ALU: begin
                if (alu_done)       nxt = gameover ? S_OVER : S_DISPLAY;
                else if (wd_expire) begin nxt = S_IDLE; wd_fire = 1'b1; end
            end
            S_DISPLAY: begin
                if (display_done)   nxt = S_WAIT_IN;
                else if (wd_expire) begin nxt = S_IDLE; wd_fire = 1'b1; end
            end
            S_OVER:    if (new_game) nxt = S_PLACE;
            default:   nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_r     <= S_IDLE;
            wd_cnt      <= '0;
            guess_ready <= 1'b0;
            start       <= 1'b0;
            load        <= 1'b0;
            decode      <= 1'b0;
            alu         <= 1'b0;
            display     <= 1'b0;
            data        <= '0;
            bad_input   <= 1'b0;
            game_active <= 1'b0;
            won         <= 1'b0;
            move_count  <= '0;
            fault       <= 1'b0;
        end else begin
            state_r     <= nxt;
            guess_ready <= (nxt == S_WAIT_IN);
            start       <= (nxt == S_PLACE);
            load        <= (nxt == S_LOAD);
            decode      <= (nxt == S_DECODE);
            alu         <= (nxt == S_ALU);
            display     <= (nxt == S_DISPLAY);
            game_active <= (nxt inside {S_WAIT_IN, S_LOAD, S_DECODE, S_ALU, S_DISPLAY});
            bad_input   <= (state_r == S_WAIT_IN) && !new_game && guess_valid && !guess_ok;

            if (nxt != state_r)
                wd_cnt <= '0;
            else if (state_r inside {S_PLACE, S_ALU, S_DISPLAY})
                wd_cnt <= wd_cnt + 1'b1;

            if (state_r == S_WAIT_IN && nxt == S_LOAD)
                data <= guess_data;

            if (state_r == S_ALU && alu_done && gameover)
                won <= win;

            if (state_r == S_DISPLAY && display_done && move_count != 5'd31)
                move_count <= move_count + 5'd1;

            if (wd_fire)
                fault <= 1'b1;

            if (nxt == S_PLACE && state_r != S_PLACE) begin
                move_count <= '0;
                won        <= 1'b0;
                fault      <= 1'b0;
            end
        end
    end

endmodule
